// File: rtl/gpio_apb_arbiter_if.sv
// rtl/gpio_apb_arbiter_if.sv - APB bus bundle between the arbiter and its subordinate
interface gpio_apb_arbiter_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic                 sel;
  logic                 enable;
  logic                 write;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] wData;
  logic [DataWidth-1:0] rData;
  logic                 readyOut;
  logic                 subErr;

  modport master (
    output sel, enable, write, addr, wData,
    input  rData, readyOut, subErr
  );

  modport slave (
    input  sel, enable, write, addr, wData,
    output rData, readyOut, subErr
  );
endinterface

// File: rtl/gpio_apb_arbiter.sv
// rtl/gpio_apb_arbiter.sv - two-requester round-robin arbiter driving one APB subordinate
module gpio_apb_arbiter #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int Timeout   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [AddrWidth-1:0] addr0,
  input  logic [AddrWidth-1:0] addr1,
  input  logic [DataWidth-1:0] wData0,
  input  logic [DataWidth-1:0] wData1,
  input  logic                 write0,
  input  logic                 write1,
  output logic                 done0,
  output logic                 done1,
  output logic [DataWidth-1:0] rData0,
  output logic [DataWidth-1:0] rData1,
  output logic                 err0,
  output logic                 err1,
  gpio_apb_arbiter_if.master   apb
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Last ACCESS cycle index before the transfer is aborted.
  localparam logic [7:0] WaitLast = 8'(Timeout - 1);

  state_t               state;
  state_t               state_next;
  logic                 last_grant;
  logic                 owner;
  logic [7:0]           wait_cnt;
  logic                 write_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;

  logic                 elig0;
  logic                 elig1;
  logic                 grant_valid;
  logic                 grant;
  logic                 finish_ok;
  logic                 finish_abort;

  assign apb.sel    = (state != IDLE);
  assign apb.enable = (state == ACCESS);
  assign apb.write  = write_q;
  assign apb.addr   = addr_q;
  assign apb.wData  = wdata_q;

  // Arbitration and next-state selection; a requester whose done is high this cycle sits out.
  always_comb begin
    state_next   = state;
    elig0        = 1'b0;
    elig1        = 1'b0;
    grant_valid  = 1'b0;
    grant        = 1'b0;
    finish_ok    = 1'b0;
    finish_abort = 1'b0;
    case (state)
      IDLE: begin
        elig0 = req0 & ~done0;
        elig1 = req1 & ~done1;
        if (elig0 && elig1) begin
          grant_valid = 1'b1;
          grant       = ~last_grant;
        end else if (elig0 || elig1) begin
          grant_valid = 1'b1;
          grant       = elig1;
        end
        if (grant_valid) state_next = SETUP;
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (apb.readyOut) begin
          finish_ok  = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == WaitLast) begin
          finish_abort = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Grant latch, wait counter and per-requester completion results.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      wait_cnt   <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rData0     <= '0;
      rData1     <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (grant_valid) begin
        owner      <= grant;
        last_grant <= grant;
        addr_q     <= grant ? addr1  : addr0;
        wdata_q    <= grant ? wData1 : wData0;
        write_q    <= grant ? write1 : write0;
        wait_cnt   <= '0;
      end else if (state == ACCESS && !apb.readyOut) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (finish_ok || finish_abort) begin
        if (owner) begin
          done1 <= 1'b1;
          err1  <= finish_abort | apb.subErr;
          if (finish_ok && !write_q) rData1 <= apb.rData;
        end else begin
          done0 <= 1'b1;
          err0  <= finish_abort | apb.subErr;
          if (finish_ok && !write_q) rData0 <= apb.rData;
        end
      end
    end
  end

endmodule

// File: doc/gpio_apb_arbiter.md
GPIO_APB_ARBITER -- requirements
Module: gpio_apb_arbiter

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 32, APB address width.
REQ-002 The block SHALL have parameter DataWidth, default 32, APB data width.
REQ-003 The block SHALL have parameter Timeout, default 16, maximum ACCESS cycles before abort (range 1..255).
REQ-004 The block SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have ports req0/req1  input  1  requester transfer request, held until done.
REQ-007 The block SHALL have ports addr0/addr1  input  AddrWidth  requester target address.
REQ-008 The block SHALL have ports wData0/wData1  input  DataWidth  requester write data.
REQ-009 The block SHALL have ports write0/write1  input  1  1 = write, 0 = read.
REQ-010 The block SHALL have ports done0/done1  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have ports rData0/rData1  output  DataWidth  read data, valid with done.
REQ-012 The block SHALL have ports err0/err1  output  1  error flag, valid with done.
REQ-013 The block SHALL have ports sel, enable, write  output  1  APB PSEL, PENABLE, PWRITE.
REQ-014 The block SHALL have ports addr  output  AddrWidth, wData  output  DataWidth  APB PADDR, PWDATA.
REQ-015 The block SHALL have ports rData  input  DataWidth, readyOut  input  1, subErr  input  1  APB PRDATA, PREADY, PSLVERR.

Function
REQ-016 The block SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-017 In IDLE, an eligible requester is one with req high and its done low this cycle.
REQ-018 In IDLE with exactly one eligible requester, the block SHALL grant it and go to SETUP next cycle.
REQ-019 In IDLE with both eligible, the block SHALL grant the requester not granted last (round-robin via lastGrant bit).
REQ-020 On grant, the block SHALL latch the granted addrN, wDataN, writeN and update lastGrant; APB outputs SHALL drive the latched values until return to IDLE.
REQ-021 SETUP: sel=1, enable=0; next state ACCESS unconditionally.
REQ-022 ACCESS: sel=1, enable=1; wait-counter increments each cycle readyOut=0.
REQ-023 ACCESS with readyOut=1: next state IDLE; next cycle doneN=1 for the granted requester, rDataN=rData (reads only, writes leave rDataN unchanged), errN=subErr.
REQ-024 ACCESS with readyOut=0 and wait-counter reaching Timeout: abort; next state IDLE, next cycle doneN=1, errN=1, rDataN unchanged.
REQ-025 In IDLE, sel=0 and enable=0; addr, wData, write SHALL hold the last latched values.
REQ-026 done0 and done1 SHALL never be high in the same cycle; each is high for exactly one cycle per transfer.
REQ-027 errN SHALL hold its value until the next doneN pulse; rDataN likewise.
REQ-028 Minimum latency: req high in IDLE at cycle N -> SETUP N+1, ACCESS N+2, done N+3 with zero wait states.
REQ-029 Requester dropping req after grant SHALL NOT abort the transfer; it completes and pulses done.
REQ-030 The wait-counter SHALL clear on entering SETUP.

Reset
REQ-031 reset high at a clock edge SHALL force IDLE and clear sel, enable, write, addr, wData, done0/1, rData0/1, err0/1, and the wait-counter to 0.
REQ-032 reset SHALL set lastGrant=1, so requester 0 wins the first tie.
REQ-033 reset mid-transfer SHALL abandon the transfer without a done pulse; sel drops the cycle after reset is sampled.

Verification
REQ-034 Single write: req0=1, addr0=0x04, wData0=0x00FF, write0=1, readyOut=1 -> sel rises N+1, enable N+2, done0=1 at N+3, err0=0.
REQ-035 Read with 3 wait states: req1 read of 0x00, readyOut high on the 4th ACCESS cycle, rData=0xA5A5 -> done1 pulses once, rData1=0xA5A5; addr held stable throughout.
REQ-036 Simultaneous requests after reset: req0=req1=1 continuously -> grants alternate 0,1,0,1; no done overlap.
REQ-037 Timeout: readyOut held 0, Timeout=16 -> abort after 16 ACCESS cycles, done0=1, err0=1, next state IDLE.
REQ-038 Subordinate error: readyOut=1 with subErr=1 -> errN=1 with doneN; next transfer with subErr=0 clears errN.
REQ-039 Reset during ACCESS -> no done pulse; all outputs 0 next cycle; subsequent tie grants requester 0.
